// File: rtl/exec_writeback_stage.sv
// Single-entry pipeline stage after the ALU: registers the result, holds the
// architectural carry flag, resolves branches and drives register writeback.
module exec_writeback_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_carry,
  input  logic               alu_zero,
  input  logic               alu_sign,
  input  logic [3:0]         alu_ops,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic               reg_write,
  input  logic [3:0]         br_type,
  input  logic [DATA_W-1:0]  br_target,
  input  logic [DATA_W-1:0]  pc_plus4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               wb_en,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               carry_flag,
  output logic               branch_taken,
  output logic [DATA_W-1:0]  branch_pc,
  output logic               flush,
  output logic [CNT_W-1:0]   retired_cnt,
  output logic [CNT_W-1:0]   taken_cnt
);

  localparam logic [3:0] OP_ADD = 4'b1010;

  localparam logic [3:0] BR_NONE = 4'b0000;
  localparam logic [3:0] BR_B    = 4'b0001;
  localparam logic [3:0] BR_BR   = 4'b0010;
  localparam logic [3:0] BR_BLTZ = 4'b0011;
  localparam logic [3:0] BR_BZ   = 4'b0100;
  localparam logic [3:0] BR_BNZ  = 4'b0101;
  localparam logic [3:0] BR_BL   = 4'b0110;
  localparam logic [3:0] BR_BCY  = 4'b0111;
  localparam logic [3:0] BR_BNCY = 4'b1000;

  localparam logic [RADDR_W-1:0] LINK_REG = RADDR_W'(31);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; valid is held and data kept stable until that edge.
  logic accept;
  logic retire;

  logic               valid_q;
  logic               wr_q;
  logic               taken_q;

  logic               taken_d;
  logic               wr_d;
  logic [RADDR_W-1:0] addr_d;
  logic [DATA_W-1:0]  data_d;
  logic [DATA_W-1:0]  pc_d;

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign retire   = valid_q & out_ready;

  // Branch resolution uses the carry flag as it stands before this
  // instruction's own update.
  always_comb begin
    taken_d = 1'b0;
    wr_d    = reg_write;
    addr_d  = rd_addr;
    data_d  = alu_result;
    pc_d    = br_target;
    case (br_type)
      BR_NONE: taken_d = 1'b0;
      BR_B:    taken_d = 1'b1;
      BR_BR: begin
        taken_d = 1'b1;
        pc_d    = alu_result;
      end
      BR_BLTZ: taken_d = alu_sign;
      BR_BZ:   taken_d = alu_zero;
      BR_BNZ:  taken_d = ~alu_zero;
      BR_BL: begin
        taken_d = 1'b1;
        wr_d    = 1'b1;
        addr_d  = LINK_REG;
        data_d  = pc_plus4;
      end
      BR_BCY:  taken_d = carry_flag;
      BR_BNCY: taken_d = ~carry_flag;
      default: begin
        taken_d = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
    if (!taken_d) pc_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      wr_q        <= 1'b0;
      taken_q     <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      branch_pc   <= '0;
      carry_flag  <= 1'b0;
      retired_cnt <= '0;
      taken_cnt   <= '0;
    end else begin
      if (accept && alu_ops == OP_ADD) carry_flag <= alu_carry;

      if (accept) begin
        valid_q   <= 1'b1;
        wr_q      <= wr_d;
        taken_q   <= taken_d;
        wb_addr   <= addr_d;
        wb_data   <= data_d;
        branch_pc <= pc_d;
      end else if (retire) begin
        valid_q <= 1'b0;
      end

      if (retire) begin
        retired_cnt <= retired_cnt + 1'b1;
        if (taken_q) taken_cnt <= taken_cnt + 1'b1;
      end
    end
  end

  assign out_valid    = valid_q;
  assign wb_en        = valid_q & wr_q;
  assign branch_taken = valid_q & taken_q;
  assign flush        = retire & taken_q;

endmodule

// File: tb/tb_exec_writeback_stage.sv
// Directed bench for exec_writeback_stage: a vector table of single-cycle
// transactions plus hand-written stall, async-reset and counter-wrap sequences.
module tb_exec_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_zero;
  logic        alu_sign;
  logic [3:0]  alu_ops;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic [3:0]  br_type;
  logic [31:0] br_target;
  logic [31:0] pc_plus4;
  logic        out_valid;
  logic        out_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        carry_flag;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic        flush;
  logic [15:0] retired_cnt;
  logic [15:0] taken_cnt;

  logic        d4_in_ready, d4_out_valid, d4_wb_en, d4_carry_flag;
  logic        d4_branch_taken, d4_flush;
  logic [4:0]  d4_wb_addr;
  logic [31:0] d4_wb_data, d4_branch_pc;
  logic [3:0]  d4_retired_cnt, d4_taken_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exec_writeback_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_sign(alu_sign), .alu_ops(alu_ops), .rd_addr(rd_addr),
    .reg_write(reg_write), .br_type(br_type), .br_target(br_target),
    .pc_plus4(pc_plus4), .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .carry_flag(carry_flag), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .flush(flush), .retired_cnt(retired_cnt),
    .taken_cnt(taken_cnt)
  );

  exec_writeback_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d4_in_ready),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_sign(alu_sign), .alu_ops(alu_ops), .rd_addr(rd_addr),
    .reg_write(reg_write), .br_type(br_type), .br_target(br_target),
    .pc_plus4(pc_plus4), .out_valid(d4_out_valid), .out_ready(out_ready),
    .wb_en(d4_wb_en), .wb_addr(d4_wb_addr), .wb_data(d4_wb_data),
    .carry_flag(d4_carry_flag), .branch_taken(d4_branch_taken),
    .branch_pc(d4_branch_pc), .flush(d4_flush), .retired_cnt(d4_retired_cnt),
    .taken_cnt(d4_taken_cnt)
  );

  typedef struct {
    logic [3:0]  br;
    logic [3:0]  ops;
    logic [31:0] res;
    logic        cy;
    logic        z;
    logic        s;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] tgt;
    logic [31:0] pc4;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_tk;
    logic [31:0] e_pc;
    logic        e_cy;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic [3:0] br, logic [3:0] ops, logic [31:0] res,
                              logic cy, logic z, logic s, logic [4:0] rd, logic rw,
                              logic [31:0] tgt, logic [31:0] pc4, logic e_en,
                              logic [4:0] e_addr, logic [31:0] e_data, logic e_tk,
                              logic [31:0] e_pc, logic e_cy);
    vec_t v;
    v.br = br; v.ops = ops; v.res = res; v.cy = cy; v.z = z; v.s = s;
    v.rd = rd; v.rw = rw; v.tgt = tgt; v.pc4 = pc4;
    v.e_en = e_en; v.e_addr = e_addr; v.e_data = e_data;
    v.e_tk = e_tk; v.e_pc = e_pc; v.e_cy = e_cy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid   = 1'b1;
    br_type    = v.br;
    alu_ops    = v.ops;
    alu_result = v.res;
    alu_carry  = v.cy;
    alu_zero   = v.z;
    alu_sign   = v.s;
    rd_addr    = v.rd;
    reg_write  = v.rw;
    br_target  = v.tgt;
    pc_plus4   = v.pc4;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    br_type    = 4'h0;
    alu_ops    = 4'h0;
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_zero   = 1'b0;
    alu_sign   = 1'b0;
    rd_addr    = '0;
    reg_write  = 1'b0;
    br_target  = '0;
    pc_plus4   = '0;
  endtask

  initial begin
    // br ops res cy z s rd rw tgt pc4 | en addr data tk pc carry
    vecs[0]  = mk(4'h0, 4'hA, 32'h0,        1, 1, 0, 5'd3,  1, 32'h0,   32'h0,  1, 5'd3,  32'h0,        0, 32'h0,    1);
    vecs[1]  = mk(4'h0, 4'h6, 32'h5,        0, 0, 0, 5'd4,  1, 32'h44,  32'h0,  1, 5'd4,  32'h5,        0, 32'h0,    1);
    vecs[2]  = mk(4'h7, 4'h0, 32'h0,        0, 1, 0, 5'd0,  0, 32'h100, 32'h0,  0, 5'd0,  32'h0,        1, 32'h100,  1);
    vecs[3]  = mk(4'h8, 4'hA, 32'h7,        0, 0, 0, 5'd5,  1, 32'h150, 32'h0,  1, 5'd5,  32'h7,        0, 32'h0,    0);
    vecs[4]  = mk(4'h8, 4'h0, 32'h0,        1, 0, 0, 5'd0,  0, 32'h200, 32'h0,  0, 5'd0,  32'h0,        1, 32'h200,  0);
    vecs[5]  = mk(4'h4, 4'h0, 32'h9,        0, 0, 0, 5'd0,  0, 32'h250, 32'h0,  0, 5'd0,  32'h9,        0, 32'h0,    0);
    vecs[6]  = mk(4'h4, 4'h0, 32'h0,        0, 1, 0, 5'd0,  0, 32'h300, 32'h0,  0, 5'd0,  32'h0,        1, 32'h300,  0);
    vecs[7]  = mk(4'h5, 4'h0, 32'h0,        0, 1, 0, 5'd0,  0, 32'h350, 32'h0,  0, 5'd0,  32'h0,        0, 32'h0,    0);
    vecs[8]  = mk(4'h3, 4'h0, 32'h80000000, 0, 0, 1, 5'd0,  0, 32'h400, 32'h0,  0, 5'd0,  32'h80000000, 1, 32'h400,  0);
    vecs[9]  = mk(4'h2, 4'h0, 32'h1234,     0, 0, 0, 5'd6,  1, 32'h999, 32'h0,  1, 5'd6,  32'h1234,     1, 32'h1234, 0);
    vecs[10] = mk(4'h6, 4'h0, 32'h77,       0, 0, 0, 5'd7,  0, 32'h500, 32'h40, 1, 5'd31, 32'h40,       1, 32'h500,  0);
    vecs[11] = mk(4'hB, 4'h0, 32'h55,       0, 1, 1, 5'd9,  1, 32'h600, 32'h0,  0, 5'd9,  32'h55,       0, 32'h0,    0);
    vecs[12] = mk(4'h1, 4'h0, 32'h0,        0, 0, 0, 5'd0,  0, 32'h600, 32'h0,  0, 5'd0,  32'h0,        1, 32'h600,  0);
    vecs[13] = mk(4'h0, 4'h0, 32'h66,       0, 0, 0, 5'd10, 0, 32'h0,   32'h0,  0, 5'd10, 32'h66,       0, 32'h0,    0);

    // reset
    rst = 1'b1;
    out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset carry_flag", 32'(carry_flag), 0);
    chk("reset retired_cnt", 32'(retired_cnt), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // table: one accept per cycle, full throughput
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d wb_en", i), 32'(wb_en), 32'(vecs[i].e_en));
      chk($sformatf("v%0d wb_addr", i), 32'(wb_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].e_data);
      chk($sformatf("v%0d branch_taken", i), 32'(branch_taken), 32'(vecs[i].e_tk));
      chk($sformatf("v%0d branch_pc", i), branch_pc, vecs[i].e_pc);
      chk($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].e_tk));
      chk($sformatf("v%0d carry_flag", i), 32'(carry_flag), 32'(vecs[i].e_cy));
      chk($sformatf("v%0d retired_cnt", i), 32'(retired_cnt), 32'(i));
    end
    idle();
    @(posedge clk);
    #1;
    chk("drain out_valid", 32'(out_valid), 0);
    chk("drain flush", 32'(flush), 0);
    chk("drain retired_cnt", 32'(retired_cnt), 14);
    chk("drain taken_cnt", 32'(taken_cnt), 7);
    chk("drain cnt4 retired", 32'(d4_retired_cnt), 14);

    // stall: B waits three cycles behind held A, then moves in as A retires
    drive(mk(4'h0, 4'h0, 32'hA, 0, 0, 0, 5'd8, 1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    drive(mk(4'h0, 4'h0, 32'hB, 0, 0, 0, 5'd9, 1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d in_ready", k), 32'(in_ready), 0);
      chk($sformatf("stall%0d out_valid", k), 32'(out_valid), 1);
      chk($sformatf("stall%0d wb_data", k), wb_data, 32'hA);
      chk($sformatf("stall%0d wb_addr", k), 32'(wb_addr), 8);
      chk($sformatf("stall%0d retired_cnt", k), 32'(retired_cnt), 14);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    idle();
    chk("unstall wb_data", wb_data, 32'hB);
    chk("unstall wb_addr", 32'(wb_addr), 9);
    chk("unstall retired_cnt", 32'(retired_cnt), 15);
    @(posedge clk);
    #1;
    chk("stall drain out_valid", 32'(out_valid), 0);
    chk("stall drain retired_cnt", 32'(retired_cnt), 16);

    // async reset mid-stall with a held taken add
    out_ready = 1'b0;
    drive(mk(4'h1, 4'hA, 32'h33, 1, 0, 0, 5'd12, 1, 32'h700, 32'h0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    idle();
    chk("pre-rst carry_flag", 32'(carry_flag), 1);
    chk("pre-rst branch_taken", 32'(branch_taken), 1);
    chk("pre-rst flush", 32'(flush), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst out_valid", 32'(out_valid), 0);
    chk("arst carry_flag", 32'(carry_flag), 0);
    chk("arst wb_en", 32'(wb_en), 0);
    chk("arst wb_addr", 32'(wb_addr), 0);
    chk("arst wb_data", wb_data, 0);
    chk("arst branch_taken", 32'(branch_taken), 0);
    chk("arst branch_pc", branch_pc, 0);
    chk("arst flush", 32'(flush), 0);
    chk("arst retired_cnt", 32'(retired_cnt), 0);
    chk("arst taken_cnt", 32'(taken_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // counter wrap: 17 retires on the 4-bit instance
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      drive(mk(4'h0, 4'h0, 32'(k), 0, 0, 0, 5'd1, 1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
    end
    idle();
    @(posedge clk);
    #1;
    chk("wrap retired_cnt", 32'(retired_cnt), 17);
    chk("wrap cnt4 retired", 32'(d4_retired_cnt), 1);
    chk("wrap taken_cnt", 32'(taken_cnt), 0);
    chk("wrap out_valid", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
